// File: rtl/jtopl_wrseq.sv
// jtopl_wrseq: FIFO-buffered register-write sequencer driving an OPL CPU port.
// Optional status-read path enabled by defining JTOPL_WRSEQ_STATUS_EN.
module jtopl_wrseq #(
  parameter int DEPTH     = 4,
  parameter int ADDR_WAIT = 12,
  parameter int DATA_WAIT = 84
) (
  input  logic       clk,
  input  logic       rst,
  input  logic       cen,
  input  logic       req_valid,
  output logic       req_ready,
  input  logic [7:0] req_reg,
  input  logic [7:0] req_data,
  output logic       busy,
  output logic [7:0] opl_din,
  output logic       opl_addr,
  output logic       opl_cs_n,
  output logic       opl_wr_n,
  input  logic [7:0] opl_dout,
  input  logic       st_req,
  output logic       st_valid,
  output logic [7:0] st_data
);

  localparam int PW    = (DEPTH > 1) ? $clog2(DEPTH) : 1;
  localparam int AWAIT = (ADDR_WAIT < 1) ? 1 : ADDR_WAIT;
  localparam int DWAIT = (DATA_WAIT < 1) ? 1 : DATA_WAIT;
  localparam int CW    = 16;
  localparam logic [CW-1:0] ALOAD = CW'(AWAIT - 1);
  localparam logic [CW-1:0] DLOAD = CW'(DWAIT - 1);

  localparam logic [2:0] S_IDLE = 3'd0;
  localparam logic [2:0] S_AWR  = 3'd1;
  localparam logic [2:0] S_AW   = 3'd2;
  localparam logic [2:0] S_DWR  = 3'd3;
  localparam logic [2:0] S_DW   = 3'd4;
  localparam logic [2:0] S_RD   = 3'd5;

  logic [15:0]   r_mem [DEPTH];
  logic [PW-1:0] r_rdPtr;
  logic [PW-1:0] r_wrPtr;
  logic [PW:0]   r_count;
  logic [2:0]    r_state;
  logic [CW-1:0] r_wait;
  logic [7:0]    r_curData;

  logic        w_empty;
  logic        w_full;
  logic        w_push;
  logic        w_pop;
  logic        w_dispatch;
  logic        w_goWrite;
  logic        w_goRead;
  logic        w_stPending;
  logic [15:0] w_head;

  assign w_empty   = (r_count == '0);
  assign w_full    = (r_count == (PW+1)'(DEPTH));
  assign req_ready = !w_full;
  assign w_push    = req_valid && req_ready;
  assign w_head    = r_mem[r_rdPtr];

  // The end of a data wait dispatches like IDLE so back-to-back writes lose no cen.
  assign w_dispatch = cen && ((r_state == S_IDLE) || ((r_state == S_DW) && (r_wait == '0)));
  assign w_goWrite  = w_dispatch && !w_empty;
  assign w_goRead   = w_dispatch && w_empty && w_stPending;
  assign w_pop      = w_goWrite;
  assign busy       = (r_state != S_IDLE) || !w_empty || w_stPending;

  always_ff @(posedge clk) begin
    if (w_push) r_mem[r_wrPtr] <= {req_reg, req_data};
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      r_rdPtr <= '0;
      r_wrPtr <= '0;
      r_count <= '0;
    end else begin
      if (w_push) r_wrPtr <= r_wrPtr + PW'(1);
      if (w_pop)  r_rdPtr <= r_rdPtr + PW'(1);
      r_count <= r_count + (PW+1)'(w_push) - (PW+1)'(w_pop);
    end
  end

`ifdef JTOPL_WRSEQ_STATUS_EN
  logic r_stPending;

  always_ff @(posedge clk) begin
    if (rst) r_stPending <= 1'b0;
    else     r_stPending <= (r_stPending && !w_goRead) || st_req;
  end

  assign w_stPending = r_stPending;
`else
  logic w_unused;

  assign w_stPending = 1'b0;
  assign w_unused    = ^{st_req, opl_dout};
  assign st_valid    = 1'b0;
  assign st_data     = 8'h00;
`endif

  always_ff @(posedge clk) begin
    if (rst) begin
      r_state   <= S_IDLE;
      r_wait    <= '0;
      r_curData <= '0;
      opl_din   <= '0;
      opl_addr  <= 1'b0;
      opl_cs_n  <= 1'b1;
      opl_wr_n  <= 1'b1;
`ifdef JTOPL_WRSEQ_STATUS_EN
      st_valid  <= 1'b0;
      st_data   <= '0;
`endif
    end else begin
`ifdef JTOPL_WRSEQ_STATUS_EN
      st_valid <= 1'b0;
`endif
      if (cen) begin
        case (r_state)
          S_AWR: begin
            opl_cs_n <= 1'b1;
            opl_wr_n <= 1'b1;
            r_wait   <= ALOAD;
            r_state  <= S_AW;
          end
          S_AW: begin
            if (r_wait == '0) begin
              opl_addr <= 1'b1;
              opl_din  <= r_curData;
              opl_cs_n <= 1'b0;
              opl_wr_n <= 1'b0;
              r_state  <= S_DWR;
            end else begin
              r_wait <= r_wait - CW'(1);
            end
          end
          S_DWR: begin
            opl_cs_n <= 1'b1;
            opl_wr_n <= 1'b1;
            r_wait   <= DLOAD;
            r_state  <= S_DW;
          end
          S_DW: begin
            if (r_wait != '0) r_wait <= r_wait - CW'(1);
          end
          S_RD: begin
            opl_cs_n <= 1'b1;
            r_state  <= S_IDLE;
`ifdef JTOPL_WRSEQ_STATUS_EN
            st_data  <= opl_dout;
            st_valid <= 1'b1;
`endif
          end
          default: ;
        endcase

        if (w_goWrite) begin
          opl_addr  <= 1'b0;
          opl_din   <= w_head[15:8];
          r_curData <= w_head[7:0];
          opl_cs_n  <= 1'b0;
          opl_wr_n  <= 1'b0;
          r_state   <= S_AWR;
        end else if (w_goRead) begin
          opl_addr <= 1'b0;
          opl_cs_n <= 1'b0;
          opl_wr_n <= 1'b1;
          r_state  <= S_RD;
        end else if (w_dispatch) begin
          r_state <= S_IDLE;
        end
      end
    end
  end

endmodule

// File: tb/tb_jtopl_wrseq.sv
// tb_jtopl_wrseq: directed, table-driven bench for jtopl_wrseq (default parameters).
// Status-read checks follow JTOPL_WRSEQ_STATUS_EN.
module tb_jtopl_wrseq;

  logic       clk = 1'b0;
  logic       rst;
  logic       cen = 1'b0;
  logic       req_valid;
  logic       req_ready;
  logic [7:0] req_reg;
  logic [7:0] req_data;
  logic       busy;
  logic [7:0] opl_din;
  logic       opl_addr;
  logic       opl_cs_n;
  logic       opl_wr_n;
  logic [7:0] opl_dout;
  logic       st_req;
  logic       st_valid;
  logic [7:0] st_data;

  int clkCount  = 0;
  int nChecks   = 0;
  int nFail     = 0;
  int cenDiv    = 1;
  int cenPhase  = 0;
  bit cenHold   = 1'b0;

  typedef struct {
    logic [7:0] regIdx;
    logic [7:0] dataVal;
    int         div;
    int         expStrobe;
    int         expAddrGap;
    int         expDataTail;
  } vec_t;

  vec_t vecs [3];
  logic [7:0] b2bReg  [5];
  logic [7:0] b2bData [5];

  jtopl_wrseq dut (
    .clk(clk), .rst(rst), .cen(cen),
    .req_valid(req_valid), .req_ready(req_ready),
    .req_reg(req_reg), .req_data(req_data), .busy(busy),
    .opl_din(opl_din), .opl_addr(opl_addr), .opl_cs_n(opl_cs_n), .opl_wr_n(opl_wr_n),
    .opl_dout(opl_dout), .st_req(st_req), .st_valid(st_valid), .st_data(st_data)
  );

  always #5 clk = ~clk;

  always @(posedge clk) clkCount <= clkCount + 1;

  // cen is one clk in every cenDiv, changed on the falling edge away from sampling
  always @(negedge clk) begin
    if (cenHold) begin
      cen = 1'b0;
    end else begin
      cenPhase = (cenPhase + 1 >= cenDiv) ? 0 : cenPhase + 1;
      cen = (cenPhase == 0);
    end
  end

  task automatic checkOutput(input string name, input int actual, input int expected);
    nChecks++;
    if (actual !== expected) begin
      nFail++;
      $display("[TB] FAIL %s: got %0d (0x%0h), expected %0d (0x%0h)", name, actual, actual, expected, expected);
    end
  endtask

  function automatic logic pick(input int which);
    case (which)
      0:       return opl_wr_n;
      1:       return busy;
      default: return opl_cs_n;
    endcase
  endfunction

  // Polls one signal after each rising edge; timeout is scored as a failure.
  task automatic waitSig(input int which, input logic level, input int limit, output int t);
    t = -1;
    for (int i = 0; i < limit; i++) begin
      @(posedge clk);
      #1;
      if (pick(which) === level) begin
        t = clkCount;
        return;
      end
    end
    nChecks++;
    nFail++;
    $display("[TB] FAIL timeout waiting on signal %0d for level %0b after %0d clk", which, level, limit);
  endtask

  task automatic applyStimulus(input logic [7:0] r, input logic [7:0] d);
    int guard;
    @(negedge clk);
    req_valid = 1'b1;
    req_reg   = r;
    req_data  = d;
    guard = 0;
    while (!req_ready && guard < 500) begin
      @(negedge clk);
      guard++;
    end
    @(negedge clk);
    req_valid = 1'b0;
  endtask

  initial begin
    int t0, t1, t2, t3, t4, prevT, nLow, nValid, rdT;
    logic [7:0] seenData;

    rst = 1'b1; req_valid = 1'b0; req_reg = '0; req_data = '0;
    opl_dout = 8'h00; st_req = 1'b0;

    vecs[0] = '{8'h20, 8'h01, 1, 1, 12, 84};
    vecs[1] = '{8'hA0, 8'h55, 4, 4, 48, 336};
    vecs[2] = '{8'hB0, 8'h2A, 2, 2, 24, 168};
    b2bReg  = '{8'h40, 8'h41, 8'h42, 8'h43, 8'h44};
    b2bData = '{8'h10, 8'h11, 8'h12, 8'h13, 8'h14};

    repeat (3) @(posedge clk);
    #1;
    checkOutput("rst_req_ready", req_ready, 1);
    checkOutput("rst_busy", busy, 0);
    checkOutput("rst_cs_n", opl_cs_n, 1);
    checkOutput("rst_wr_n", opl_wr_n, 1);
    checkOutput("rst_din", opl_din, 0);
    checkOutput("rst_addr", opl_addr, 0);
    checkOutput("rst_st_valid", st_valid, 0);
    checkOutput("rst_st_data", st_data, 0);
    @(negedge clk);
    rst = 1'b0;

    for (int v = 0; v < 3; v++) begin
      cenDiv = vecs[v].div;
      applyStimulus(vecs[v].regIdx, vecs[v].dataVal);
      waitSig(0, 1'b0, 50, t0);
      checkOutput("aw_addr", opl_addr, 0);
      checkOutput("aw_din", opl_din, vecs[v].regIdx);
      checkOutput("aw_cs_n", opl_cs_n, 0);
      waitSig(0, 1'b1, 50, t1);
      checkOutput("aw_strobe_clk", t1 - t0, vecs[v].expStrobe);
      waitSig(0, 1'b0, 1000, t2);
      checkOutput("addr_wait_clk", t2 - t1, vecs[v].expAddrGap);
      checkOutput("dw_addr", opl_addr, 1);
      checkOutput("dw_din", opl_din, vecs[v].dataVal);
      waitSig(0, 1'b1, 50, t3);
      checkOutput("dw_strobe_clk", t3 - t2, vecs[v].expStrobe);
      waitSig(1, 1'b0, 2000, t4);
      checkOutput("data_wait_clk", t4 - t3, vecs[v].expDataTail);
    end

    // Fill the FIFO with cen held off, then push a fifth entry across the first pop
    cenDiv = 1;
    @(posedge clk); #1; cenHold = 1'b1;
    for (int i = 0; i < 4; i++) applyStimulus(b2bReg[i], b2bData[i]);
    checkOutput("full_ready", req_ready, 0);
    checkOutput("full_busy", busy, 1);
    @(negedge clk);
    req_valid = 1'b1; req_reg = b2bReg[4]; req_data = b2bData[4];
    @(posedge clk); #1; cenHold = 1'b0;
    waitSig(0, 1'b0, 10, t0);
    checkOutput("pop_refused_ready", req_ready, 1);
    @(posedge clk); #1;
    checkOutput("refill_ready", req_ready, 0);
    @(negedge clk);
    req_valid = 1'b0;
    prevT = t0;
    for (int i = 0; i < 5; i++) begin
      if (i > 0) begin
        waitSig(0, 1'b0, 200, t0);
        checkOutput("b2b_period_clk", t0 - prevT, 98);
        prevT = t0;
      end
      checkOutput("b2b_addr_phase", opl_addr, 0);
      checkOutput("b2b_reg", opl_din, b2bReg[i]);
      waitSig(0, 1'b1, 10, t1);
      waitSig(0, 1'b0, 50, t2);
      checkOutput("b2b_data", opl_din, b2bData[i]);
      waitSig(0, 1'b1, 10, t3);
    end
    waitSig(1, 1'b0, 200, t4);

    // Reset in the middle of an address wait with three entries still queued
    @(posedge clk); #1; cenHold = 1'b1;
    for (int i = 0; i < 4; i++) applyStimulus(b2bReg[i], b2bData[i]);
    @(posedge clk); #1; cenHold = 1'b0;
    waitSig(0, 1'b0, 10, t0);
    waitSig(0, 1'b1, 10, t1);
    repeat (4) @(posedge clk);
    @(negedge clk);
    rst = 1'b1;
    @(posedge clk); #1;
    checkOutput("midrst_cs_n", opl_cs_n, 1);
    checkOutput("midrst_wr_n", opl_wr_n, 1);
    checkOutput("midrst_busy", busy, 0);
    checkOutput("midrst_ready", req_ready, 1);
    @(negedge clk);
    rst = 1'b0;
    nLow = 0;
    for (int i = 0; i < 300; i++) begin
      @(posedge clk); #1;
      if (opl_wr_n === 1'b0 || opl_cs_n === 1'b0) nLow++;
    end
    checkOutput("postrst_bus_activity", nLow, 0);
    checkOutput("postrst_busy", busy, 0);

    opl_dout = 8'hE0;
`ifdef JTOPL_WRSEQ_STATUS_EN
    // Two status requests during the data wait collapse into one read after it
    applyStimulus(8'h60, 8'h77);
    waitSig(0, 1'b0, 20, t0);
    waitSig(0, 1'b1, 10, t1);
    waitSig(0, 1'b0, 50, t2);
    waitSig(0, 1'b1, 10, t3);
    repeat (10) @(negedge clk);
    st_req = 1'b1; @(negedge clk); st_req = 1'b0;
    repeat (5) @(negedge clk);
    st_req = 1'b1; @(negedge clk); st_req = 1'b0;
    nValid = 0; rdT = -1; seenData = 8'h00;
    for (int i = 0; i < 150; i++) begin
      @(posedge clk); #1;
      if (st_valid === 1'b1) begin
        nValid++;
        seenData = st_data;
      end
      if (rdT < 0 && opl_cs_n === 1'b0 && opl_wr_n === 1'b1) begin
        rdT = clkCount;
        checkOutput("rd_addr", opl_addr, 0);
      end
    end
    checkOutput("rd_after_dw_clk", rdT - t3, 84);
    checkOutput("st_valid_pulses", nValid, 1);
    checkOutput("st_data_capture", seenData, 8'hE0);
    checkOutput("st_busy_done", busy, 0);
`else
    @(negedge clk);
    st_req = 1'b1; @(negedge clk); st_req = 1'b0;
    #1;
    checkOutput("nost_busy", busy, 0);
    nValid = 0;
    for (int i = 0; i < 200; i++) begin
      @(posedge clk); #1;
      if (st_valid !== 1'b0) nValid++;
      if (opl_cs_n === 1'b0) nValid++;
    end
    checkOutput("nost_st_valid", nValid, 0);
    checkOutput("nost_st_data", st_data, 0);
`endif

    $display("End of test - %0d assertions evaluated, %0d failures", nChecks, nFail);
    $finish;
  end

endmodule
